mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle RISC-V control unit: Moore main FSM plus ALU and immediate decoders.
//  Sits directly upstream of the miniproj4 datapath registers (PC, IR, OldPC, A/B, ALUOut, Data).
//  Drives their load enables and the datapath mux selects, one instruction every 3-5 cycles.
//  Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.
//  Any other opcode parks the FSM in TRAP.
// PARAMETERS
//  none. All widths are fixed by RV32I encoding.
// PORTS
//  clk          in   1  clock; all state updates on posedge
//  reset        in   1  asynchronous, active-low (0 = in reset); forces state to FETCH
//  op           in   7  instr[6:0], valid from IR (stable from DECODE onward)
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU zero flag, same cycle (combinational from datapath)
//  pc_write     out  1  PC load enable = pc_update | (branch & zero)
//  adr_src      out  1  memory address: 0 PC, 1 ALUOut
//  mem_write    out  1  data memory write strobe
//  ir_write     out  1  IR and OldPC load enable
//  result_src   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 A
//  alu_src_b    out  2  00 B, 01 ImmExt, 10 const 4
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J (decoded from op; 00 for unknown op)
//  reg_write    out  1  register file write enable
//  alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  instr_done   out  1  1-cycle pulse in the last state of each instruction
//  trap         out  1  high while in TRAP
// BEHAVIOUR
//  Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
//  Moore outputs decoded from state. Each output is 0/00 except where listed below.
//  alu_control is derived from alu_op as listed under ALU decode.
//  FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_update=1.
//    Next state DECODE.
//  DECODE: alu_src_a=01, alu_src_b=01, alu_op=add.
//    Next: lw/sw->MEMADR, R->EXECR, I->EXECI, beq->BEQ, jal->JAL, else->TRAP.
//  MEMADR: alu_src_a=10, alu_src_b=01. Next: lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: result_src=00, adr_src=1. Next MEMWB.
//  MEMWB: result_src=01, reg_write=1, instr_done=1. Next FETCH.
//  MEMWRITE: result_src=00, adr_src=1, mem_write=1, instr_done=1. Next FETCH.
//  EXECR: alu_src_a=10, alu_src_b=00, alu_op=funct. Next ALUWB.
//  EXECI: alu_src_a=10, alu_src_b=01, alu_op=funct. Next ALUWB.
//  ALUWB: result_src=00, reg_write=1, instr_done=1. Next FETCH.
//  BEQ: alu_src_a=10, alu_src_b=00, alu_op=sub, result_src=00, branch=1, instr_done=1.
//    Next FETCH.
//  JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1, alu_op=add.
//    Next ALUWB (ALUWB asserts instr_done).
//  TRAP: trap=1, all enables 0. Stays in TRAP until reset asserts.
//  ALU decode, alu_op=funct: funct3 000 -> sub only if funct7b5 & op[5], else add;
//    010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
//  Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
//  Reset: while reset==0, state=FETCH, and pc_write, ir_write, mem_write and reg_write
//    are forced 0 (combinational gate on reset).
//    Other outputs show FETCH decode: adr_src=0, alu_src_b=10, result_src=10.
//    Release takes effect at the first posedge with reset==1; FETCH enables are live that cycle.
//  Reset mid-instruction (any state): abandon it, return to FETCH, no partial write issued.
//  beq: pc_write samples zero combinationally in BEQ only; zero is ignored in all other states.
//  Unknown funct3 on R/I: no trap; executes as add.
// STRUCTURE
//  Package mc_ctrl_pkg holds:
//    state_t enum {FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB,
//      BEQ, JAL, TRAP};
//    opcode localparams; alu_op_t {ADD, SUB, FUNCT}; ALU control and mux-select encodings.
//  Sub-module alu_decoder (combinational): alu_op, funct3, funct7b5, op[5] -> alu_control.
//  Top module holds the state register (async active-low reset), next-state logic,
//    output decode and imm_src decode.
// TESTING
//  lw (op 0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5;
//    instr_done pulses once.
//  sw: mem_write=1 only in cycle 4 with adr_src=1; imm_src=01 from DECODE; reg_write never 1.
//  R sub (funct3 000, funct7b5 1): alu_control=001 in EXECR.
//    addi with funct7b5=1: alu_control=000 in EXECI.
//  beq with zero=1 in BEQ -> pc_write=1; zero=0 -> pc_write=0.
//    zero=1 during DECODE -> pc_write=0; next state FETCH in both cases.
//  Illegal op 0000000 -> TRAP after DECODE; trap=1 and all enables 0 for 20 cycles.
//    reset=0 -> FETCH.
//  Assert reset=0 during MEMREAD of lw -> state FETCH immediately, and no reg_write pulse.
//    Write enables stay 0 until release; first post-release cycle has ir_write=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg: shared types and encodings for the multicycle RV32 control unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_CTL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTL_AND = 3'b010;
  localparam logic [2:0] ALU_CTL_OR  = 3'b011;
  localparam logic [2:0] ALU_CTL_SLT = 3'b101;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word produced by the state decoder, before reset gating.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    alu_op_t    alu_op;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder: maps alu_op and instruction function fields to alu_control.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  logic is_sub;

  // Only R-type (op[5]=1) can request sub; addi ignores funct7b5.
  assign is_sub = funct7b5 & op5;

  always_comb begin
    alu_control = ALU_CTL_ADD;
    case (alu_op)
      ADD: alu_control = ALU_CTL_ADD;
      SUB: alu_control = ALU_CTL_SUB;
      FUNCT: begin
        case (funct3)
          F3_ADDSUB: alu_control = is_sub ? ALU_CTL_SUB : ALU_CTL_ADD;
          F3_SLT:    alu_control = ALU_CTL_SLT;
          F3_OR:     alu_control = ALU_CTL_OR;
          F3_AND:    alu_control = ALU_CTL_AND;
          default:   alu_control = ALU_CTL_ADD;
        endcase
      end
      default: alu_control = ALU_CTL_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm: multicycle RV32 control unit (Moore FSM, ALU and imm decode).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       trap
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP;
        endcase
      end
      // op is held stable by IR, so a non-memory op here can only be corruption.
      MEMADR: begin
        if (op == OP_LW) begin
          state_next = MEMREAD;
        end else if (op == OP_SW) begin
          state_next = MEMWRITE;
        end else begin
          state_next = TRAP;
        end
      end
      MEMREAD:  state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      JAL:      state_next = ALUWB;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ADD;
    case (state)
      FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = FUNCT;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = FUNCT;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
        ctrl.alu_op     = ADD;
      end
      TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: begin
        ctrl        = '0;
        ctrl.alu_op = ADD;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  // Write enables are gated by reset itself so no strobe escapes while held.
  assign pc_write   = reset & (ctrl.pc_update | (ctrl.branch & zero));
  assign ir_write   = reset & ctrl.ir_write;
  assign mem_write  = reset & ctrl.mem_write;
  assign reg_write  = reset & ctrl.reg_write;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign instr_done = ctrl.instr_done;
  assign trap       = ctrl.trap;
  assign imm_src    = imm_src_of(op);

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm: self-checking bench for the multicycle control unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, trap;

  int checks = 0;
  int errors = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
    .alu_control(alu_control), .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // Output word: {pcw, adr, mw, irw, rs[2], a[2], b[2], imm[2], rw, alu[3], done, trap}
  function automatic logic [17:0] pack(logic pcw, logic adr, logic mw, logic irw,
      logic [1:0] rs, logic [1:0] a, logic [1:0] b, logic [1:0] imm, logic rw,
      logic [2:0] alu, logic dn, logic tr);
    return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, dn, tr};
  endfunction

  function automatic logic [17:0] actual();
    return pack(pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, alu_control, instr_done, trap);
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_fn(logic [2:0] f3, logic want_sub);
    case (f3)
      3'b000:  return want_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int cycles_of(logic [6:0] o, int trap_cycles);
    case (o)
      LW:      return 5;
      SW, RT, IT, JL: return 4;
      BQ:      return 3;
      default: return 2 + trap_cycles;
    endcase
  endfunction

  // Reference: expected outputs in cycle k of an instruction, given zero that cycle.
  function automatic logic [17:0] model(logic [6:0] o, logic [2:0] f3, logic f7, int k, logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, dn = 0, tr = 0;
    logic [1:0] rs = 0, a = 0, b = 0;
    logic [2:0] alu = 0;
    if (k == 0) begin
      irw = 1; pcw = 1; b = 2'b10; rs = 2'b10;
    end else if (k == 1) begin
      a = 2'b01; b = 2'b01;
    end else begin
      case (o)
        LW: if (k == 2) begin a = 2'b10; b = 2'b01; end
            else if (k == 3) adr = 1;
            else begin rs = 2'b01; rw = 1; dn = 1; end
        SW: if (k == 2) begin a = 2'b10; b = 2'b01; end
            else begin adr = 1; mw = 1; dn = 1; end
        RT: if (k == 2) begin a = 2'b10; alu = alu_fn(f3, f7); end
            else begin rw = 1; dn = 1; end
        IT: if (k == 2) begin a = 2'b10; b = 2'b01; alu = alu_fn(f3, 1'b0); end
            else begin rw = 1; dn = 1; end
        BQ: begin a = 2'b10; alu = 3'b001; pcw = z; dn = 1; end
        JL: if (k == 2) begin a = 2'b01; b = 2'b10; pcw = 1; end
            else begin rw = 1; dn = 1; end
        default: tr = 1;
      endcase
    end
    return pack(pcw, adr, mw, irw, rs, a, b, imm_of(o), rw, alu, dn, tr);
  endfunction

  function automatic logic [17:0] reset_sig(logic [6:0] o);
    return pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(o), 0, 3'b000, 0, 0);
  endfunction

  task automatic check(string nm, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int ncyc, input logic [31:0] zpat,
                           output int lat, output logic [2:0] alu2);
    lat = 0;
    alu2 = 3'bxxx;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin op = o; funct3 = f3; funct7b5 = f7; end
      zero = zpat[k];
      #3;
      check($sformatf("op%b f3%b c%0d", o, f3, k), actual(), model(o, f3, f7, k, zpat[k]));
      if (instr_done === 1'b1 && lat == 0) lat = k + 1;
      if (k == 2) alu2 = alu_control;
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         lat;
    logic [2:0] alu2;
  } vec_t;

  vec_t vecs[14];
  logic [6:0] legal[6];

  initial begin
    int lat;
    logic [2:0] alu2;
    logic [6:0] o;
    vecs[0]  = '{LW, 3'b010, 1'b0, 5, 3'b000};
    vecs[1]  = '{SW, 3'b010, 1'b0, 4, 3'b000};
    vecs[2]  = '{RT, 3'b000, 1'b1, 4, 3'b001};
    vecs[3]  = '{RT, 3'b000, 1'b0, 4, 3'b000};
    vecs[4]  = '{RT, 3'b010, 1'b0, 4, 3'b101};
    vecs[5]  = '{RT, 3'b110, 1'b0, 4, 3'b011};
    vecs[6]  = '{RT, 3'b111, 1'b1, 4, 3'b010};
    vecs[7]  = '{RT, 3'b001, 1'b0, 4, 3'b000};
    vecs[8]  = '{IT, 3'b000, 1'b1, 4, 3'b000};
    vecs[9]  = '{IT, 3'b010, 1'b0, 4, 3'b101};
    vecs[10] = '{IT, 3'b110, 1'b0, 4, 3'b011};
    vecs[11] = '{IT, 3'b111, 1'b0, 4, 3'b010};
    vecs[12] = '{BQ, 3'b000, 1'b0, 3, 3'b001};
    vecs[13] = '{JL, 3'b000, 1'b0, 4, 3'b000};
    legal = '{LW, SW, RT, IT, BQ, JL};

    // Held in reset: FETCH decode with all write enables forced low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zero = 1'b1;
      #3;
      check("reset_hold", actual(), reset_sig(op));
    end
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, cycles_of(vecs[i].op, 0),
                $urandom, lat, alu2);
      check_int($sformatf("latency v%0d", i), lat, vecs[i].lat);
      check_int($sformatf("alu_c2 v%0d", i), int'(alu2), int'(vecs[i].alu2));
    end

    // beq: zero in DECODE must not branch; zero in BEQ must.
    run_instr(BQ, 3'b000, 1'b0, 3, 32'b010, lat, alu2);
    run_instr(BQ, 3'b000, 1'b0, 3, 32'b100, lat, alu2);
    run_instr(BQ, 3'b000, 1'b0, 3, 32'b011, lat, alu2);

    for (int n = 0; n < 40; n++) begin
      o = legal[$urandom_range(0, 5)];
      run_instr(o, 3'($urandom), 1'($urandom), cycles_of(o, 0), $urandom, lat, alu2);
    end

    // Reset during lw MEMREAD: abandon, no reg_write, clean FETCH after release.
    run_instr(LW, 3'b010, 1'b0, 4, 32'h0, lat, alu2);
    #1 reset = 1'b0;
    #1 check("reset_in_memread", actual(), reset_sig(LW));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #3 check("reset_after_memread", actual(), reset_sig(LW));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("release_fetch", actual(), model(LW, 3'b010, 1'b0, 0, zero));
    run_instr(LW, 3'b010, 1'b0, 5, 32'h0, lat, alu2);
    check_int("lw_latency_after_reset", lat, 5);

    // Illegal opcode parks in TRAP for good until reset.
    run_instr(7'b0000000, 3'b000, 1'b0, cycles_of(7'b0000000, 20), $urandom, lat, alu2);
    check_int("trap_no_done", lat, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("reset_from_trap", actual(), reset_sig(7'b0000000));
    @(posedge clk);
    #1 reset = 1'b1;
    run_instr(RT, 3'b000, 1'b1, 4, 32'h0, lat, alu2);
    check_int("r_after_trap_latency", lat, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
